// File: rtl/bp_me_cache_dma_responder.sv
// Memory-side responder for one bsg_cache DMA port: serves block fills and absorbs
// evictions from a flop-array backing store, with a programmable fill latency.
module bp_me_cache_dma_responder #(
  parameter int addr_width_p  = 28,
  parameter int fill_width_p  = 64,
  parameter int block_width_p = 512,
  parameter int mem_els_p     = 256,
  parameter int delay_p       = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [addr_width_p:0]   dma_pkt_i,
  input  logic                    dma_pkt_v_i,
  output logic                    dma_pkt_ready_and_o,
  output logic [fill_width_p-1:0] dma_data_o,
  output logic                    dma_data_v_o,
  input  logic                    dma_data_ready_and_i,
  input  logic [fill_width_p-1:0] dma_data_i,
  input  logic                    dma_data_v_i,
  output logic                    dma_data_ready_and_o
);

  localparam int B   = block_width_p / fill_width_p;
  localparam int OFF = $clog2(fill_width_p / 8);
  localparam int AL  = $clog2(B);
  localparam int CW  = (AL > 0) ? AL : 1;
  localparam int IW  = ($clog2(mem_els_p) > 0) ? $clog2(mem_els_p) : 1;
  localparam int DW  = ($clog2(delay_p + 1) > 0) ? $clog2(delay_p + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(B - 1);
  localparam logic [DW-1:0] DLY_LAST   = DW'((delay_p > 0) ? delay_p - 1 : 0);
  localparam logic [IW-1:0] ALIGN_MASK = {IW{1'b1}} << AL;

  localparam logic [1:0] E_IDLE  = 2'd0;
  localparam logic [1:0] E_DELAY = 2'd1;
  localparam logic [1:0] E_READ  = 2'd2;
  localparam logic [1:0] E_WRITE = 2'd3;

  logic [1:0]              state, state_n;
  logic [CW-1:0]           cnt;
  logic [DW-1:0]           dcnt;
  logic [IW-1:0]           base, idx;
  logic                    live;
  logic                    pkt_fire, rd_fire, wr_fire, last_beat;
  logic [fill_width_p-1:0] mem [mem_els_p];

  // live keeps the packet port closed until the first edge after reset releases
  assign dma_pkt_ready_and_o  = live & (state == E_IDLE);
  assign dma_data_v_o         = (state == E_READ);
  assign dma_data_ready_and_o = (state == E_WRITE);

  assign pkt_fire  = dma_pkt_v_i & dma_pkt_ready_and_o;
  assign rd_fire   = dma_data_v_o & dma_data_ready_and_i;
  assign wr_fire   = dma_data_ready_and_o & dma_data_v_i;
  assign last_beat = (cnt == CNT_LAST);

  // index wraps at mem_els_p, so upper address bits alias onto the same words
  assign idx        = base + IW'(cnt);
  assign dma_data_o = dma_data_v_o ? mem[idx] : '0;

  always_comb begin
    state_n = state;
    case (state)
      E_IDLE:  if (pkt_fire)
                 state_n = dma_pkt_i[addr_width_p] ? E_WRITE
                         : ((delay_p == 0) ? E_READ : E_DELAY);
      E_DELAY: if (dcnt == DLY_LAST) state_n = E_READ;
      E_READ:  if (rd_fire && last_beat) state_n = E_IDLE;
      E_WRITE: if (wr_fire && last_beat) state_n = E_IDLE;
      default: state_n = E_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= E_IDLE;
      cnt   <= '0;
      dcnt  <= '0;
      base  <= '0;
      live  <= 1'b0;
    end else begin
      live  <= 1'b1;
      state <= state_n;
      if (pkt_fire) begin
        base <= IW'(dma_pkt_i[addr_width_p-1:0] >> OFF) & ALIGN_MASK;
        cnt  <= '0;
        dcnt <= '0;
      end else begin
        if (rd_fire || wr_fire) cnt  <= cnt + 1'b1;
        if (state == E_DELAY)   dcnt <= dcnt + 1'b1;
      end
    end
  end

  // backing store deliberately has no reset so contents survive a reset pulse
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[idx] <= dma_data_i;
  end

endmodule

// File: tb/tb_bp_me_cache_dma_responder.sv
// Bench for bp_me_cache_dma_responder: vector table, corner-case sequences and random
// block traffic checked against a word-array model of the backing store.
module tb_bp_me_cache_dma_responder;
  localparam int AW = 28, FW = 64, BW = 512, MEM = 256, DLY = 4;
  localparam int B = BW / FW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW:0]   pkt, z_pkt;
  logic          pkt_v, z_pkt_v;
  logic          pkt_rdy, z_pkt_rdy;
  logic [FW-1:0] rdata, z_rdata;
  logic          rdata_v, z_rdata_v;
  logic          rdata_rdy, z_rdata_rdy;
  logic [FW-1:0] wdata, z_wdata;
  logic          wdata_v, z_wdata_v;
  logic          wdata_rdy, z_wdata_rdy;

  bp_me_cache_dma_responder #(.addr_width_p(AW), .fill_width_p(FW), .block_width_p(BW),
    .mem_els_p(MEM), .delay_p(DLY)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .dma_pkt_i(pkt), .dma_pkt_v_i(pkt_v), .dma_pkt_ready_and_o(pkt_rdy),
    .dma_data_o(rdata), .dma_data_v_o(rdata_v), .dma_data_ready_and_i(rdata_rdy),
    .dma_data_i(wdata), .dma_data_v_i(wdata_v), .dma_data_ready_and_o(wdata_rdy));

  bp_me_cache_dma_responder #(.addr_width_p(AW), .fill_width_p(FW), .block_width_p(BW),
    .mem_els_p(MEM), .delay_p(0)) dut_z (
    .clk_i(clk), .reset_n_i(rst_n),
    .dma_pkt_i(z_pkt), .dma_pkt_v_i(z_pkt_v), .dma_pkt_ready_and_o(z_pkt_rdy),
    .dma_data_o(z_rdata), .dma_data_v_o(z_rdata_v), .dma_data_ready_and_i(z_rdata_rdy),
    .dma_data_i(z_wdata), .dma_data_v_i(z_wdata_v), .dma_data_ready_and_o(z_wdata_rdy));

  logic [63:0] mdl [MEM];
  bit          known [MEM];
  logic [63:0] wbuf [B];
  int total = 0, bad = 0;

  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    int          mode;
    logic [63:0] seed;
    int          exp_lat;
    int          exp_stalls;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // word index of beat n of the block containing byte address a
  function automatic int widx(input logic [AW-1:0] a, input int n);
    int blk;
    blk = int'(a) / 8 / B * B;
    return (blk + n) % MEM;
  endfunction

  // called at a negedge; returns at the negedge of cycle 1 after the accept
  task automatic send_pkt(input bit wr, input logic [AW-1:0] a);
    int w;
    w = 0;
    pkt = {wr, a};
    pkt_v = 1'b1;
    while (!pkt_rdy && w < 400) begin @(negedge clk); w++; end
    chk("pkt_accept", 64'(pkt_rdy), 64'd1);
    @(negedge clk);
    pkt_v = 1'b0;
  endtask

  task automatic wr_block(input logic [AW-1:0] a, input int mode);
    int cyc, beat, idx;
    bit v, pr_ok, rv_ok, rdy_ok;
    send_pkt(1'b1, a);
    cyc = 1; beat = 0; pr_ok = 1; rv_ok = 1; rdy_ok = 1;
    chk("wr_rdy_cyc1", 64'(wdata_rdy), 64'd1);
    while (beat < B && cyc < 400) begin
      if (pkt_rdy) pr_ok = 0;
      if (rdata_v) rv_ok = 0;
      v = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      wdata_v = v;
      wdata = wbuf[beat];
      if (v && !wdata_rdy) rdy_ok = 0;
      if (v && wdata_rdy) begin
        idx = widx(a, beat);
        mdl[idx] = wbuf[beat];
        known[idx] = 1'b1;
        beat++;
      end
      @(negedge clk); cyc++;
    end
    wdata_v = 1'b0;
    chk("wr_beats", 64'(beat), 64'(B));
    chk("wr_pkt_rdy_back", 64'(pkt_rdy), 64'd1);
    chk("wr_pkt_busy", 64'(pr_ok), 64'd1);
    chk("wr_no_fill_v", 64'(rv_ok), 64'd1);
    chk("wr_rdy_held", 64'(rdy_ok), 64'd1);
  endtask

  task automatic rd_block(input logic [AW-1:0] a, input int mode, input int exp_lat,
                          input int exp_stalls);
    int cyc, beat, stalls, first, idx;
    bit tog, holding, pr_ok, er_ok;
    logic r;
    logic [63:0] held;
    send_pkt(1'b0, a);
    cyc = 1; beat = 0; stalls = 0; first = -1; tog = 1; holding = 0; pr_ok = 1; er_ok = 1;
    held = '0;
    wdata_v = 1'b1;
    wdata = '1;
    while (beat < B && cyc < 400) begin
      if (holding) begin
        chk("hold_v", 64'(rdata_v), 64'd1);
        chk("hold_data", rdata, held);
        holding = 0;
      end
      if (pkt_rdy) pr_ok = 0;
      if (wdata_rdy) er_ok = 0;
      case (mode)
        0:       r = 1'b1;
        1:       r = tog;
        default: r = 1'($urandom_range(0, 1));
      endcase
      rdata_rdy = r;
      if (rdata_v) begin
        if (first < 0) first = cyc;
        if (mode == 1) tog = ~tog;
        if (r) begin
          idx = widx(a, beat);
          if (known[idx]) chk("rd_data", rdata, mdl[idx]);
          beat++;
        end else begin
          stalls++;
          held = rdata;
          holding = 1;
        end
      end
      @(negedge clk); cyc++;
    end
    rdata_rdy = 1'b0;
    wdata_v = 1'b0;
    chk("rd_beats", 64'(beat), 64'(B));
    chk("rd_latency", 64'(first), 64'(exp_lat));
    chk("rd_done_cycle", 64'(cyc), 64'(exp_lat + B + stalls));
    chk("rd_pkt_rdy_back", 64'(pkt_rdy), 64'd1);
    if (exp_stalls >= 0) chk("rd_stalls", 64'(stalls), 64'(exp_stalls));
    chk("rd_pkt_busy", 64'(pr_ok), 64'd1);
    chk("rd_evict_blocked", 64'(er_ok), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    int acc [$];
    int fv, nb, cyc, w, idx;
    bit eok;
    logic [AW-1:0] ra;

    tbl[0] = '{1'b1, 28'h40,  0, 64'h11,          0, 0};
    tbl[1] = '{1'b0, 28'h40,  0, 64'h0,           DLY + 1, 0};
    tbl[2] = '{1'b0, 28'h40,  1, 64'h0,           DLY + 1, B - 1};
    tbl[3] = '{1'b1, 28'h48,  0, 64'h101,         0, 0};
    tbl[4] = '{1'b0, 28'h40,  0, 64'h0,           DLY + 1, 0};
    tbl[5] = '{1'b1, 28'h840, 0, 64'h1_0000_0001, 0, 0};
    tbl[6] = '{1'b0, 28'h40,  2, 64'h0,           DLY + 1, -1};

    rst_n = 1'b0;
    pkt = '0; pkt_v = 1'b0; rdata_rdy = 1'b0; wdata = '0; wdata_v = 1'b0;
    z_pkt = '0; z_pkt_v = 1'b0; z_rdata_rdy = 1'b0; z_wdata = '0; z_wdata_v = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pkt_rdy", 64'(pkt_rdy), 64'd0);
    chk("rst_data_v", 64'(rdata_v), 64'd0);
    chk("rst_evict_rdy", 64'(wdata_rdy), 64'd0);
    chk("rst_data", rdata, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rdy_gated_before_edge", 64'(pkt_rdy), 64'd0);
    @(negedge clk);
    chk("rdy_after_rst", 64'(pkt_rdy), 64'd1);

    // zero-delay instance: back-to-back reads on a held-valid packet port
    z_pkt = '0; z_pkt_v = 1'b1; z_rdata_rdy = 1'b1;
    fv = -1; nb = 0;
    for (int c = 0; c < 20; c++) begin
      if (z_pkt_rdy) acc.push_back(c);
      if (z_rdata_v && fv < 0) fv = c;
      if (z_rdata_v && acc.size() == 1) nb++;
      @(negedge clk);
    end
    z_pkt_v = 1'b0;
    chk("z_accept_count", 64'(acc.size()), 64'd3);
    if (acc.size() >= 3) begin
      chk("z_first_beat", 64'(fv), 64'(acc[0] + 1));
      chk("z_spacing_0", 64'(acc[1] - acc[0]), 64'(B + 1));
      chk("z_spacing_1", 64'(acc[2] - acc[1]), 64'(B + 1));
    end
    chk("z_beats", 64'(nb), 64'(B));

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].wr) begin
        for (int b = 0; b < B; b++) wbuf[b] = tbl[i].seed * 64'(b + 1);
        wr_block(tbl[i].addr, tbl[i].mode);
      end else begin
        rd_block(tbl[i].addr, tbl[i].mode, tbl[i].exp_lat, tbl[i].exp_stalls);
      end
    end

    // reset while write beat 3 is being offered
    for (int b = 0; b < B; b++) wbuf[b] = 64'hC0DE_0000_0000_0000 + 64'(b);
    wr_block(28'h80, 0);
    for (int b = 0; b < B; b++) wbuf[b] = 64'hBEEF_0000_0000_0000 + 64'(b);
    send_pkt(1'b1, 28'h80);
    for (int b = 0; b < 3; b++) begin
      wdata_v = 1'b1;
      wdata = wbuf[b];
      mdl[widx(28'h80, b)] = wbuf[b];
      @(negedge clk);
    end
    wdata = wbuf[3];
    rdata_rdy = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_pkt_rdy", 64'(pkt_rdy), 64'd0);
    chk("midrst_evict_rdy", 64'(wdata_rdy), 64'd0);
    chk("midrst_data_v", 64'(rdata_v), 64'd0);
    @(negedge clk);
    chk("midrst_hold_evict_rdy", 64'(wdata_rdy), 64'd0);
    chk("midrst_hold_data", rdata, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_rdy_gated", 64'(pkt_rdy), 64'd0);
    @(negedge clk);
    wdata_v = 1'b0;
    rdata_rdy = 1'b0;
    chk("midrst_rdy_back", 64'(pkt_rdy), 64'd1);
    chk("midrst_idle_evict", 64'(wdata_rdy), 64'd0);
    rd_block(28'h80, 0, DLY + 1, 0);

    // second packet held valid during a read
    wdata_v = 1'b1;
    wdata = '1;
    #1;
    chk("idle_evict_blocked", 64'(wdata_rdy), 64'd0);
    send_pkt(1'b0, 28'h40);
    pkt = {1'b0, 28'h80};
    pkt_v = 1'b1;
    rdata_rdy = 1'b1;
    cyc = 1; nb = 0; eok = 1;
    while (!pkt_rdy && cyc < 100) begin
      if (wdata_rdy) eok = 0;
      if (rdata_v) nb++;
      @(negedge clk); cyc++;
    end
    chk("second_pkt_accept_cycle", 64'(cyc), 64'(DLY + B + 1));
    chk("first_pkt_beats", 64'(nb), 64'(B));
    chk("read_evict_blocked", 64'(eok), 64'd1);
    @(negedge clk);
    pkt_v = 1'b0;
    nb = 0; w = 0;
    while (nb < B && w < 50) begin
      if (rdata_v) begin
        idx = widx(28'h80, nb);
        if (known[idx]) chk("second_pkt_data", rdata, mdl[idx]);
        nb++;
      end
      @(negedge clk); w++;
    end
    chk("second_pkt_done", 64'(pkt_rdy), 64'd1);
    rdata_rdy = 1'b0;
    wdata_v = 1'b0;

    for (int t = 0; t < 40; t++) begin
      ra = AW'($urandom_range(0, 3) * 64 + $urandom_range(0, 63) + ($urandom_range(0, 3) << 11));
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < B; b++) wbuf[b] = {$urandom, $urandom};
        wr_block(ra, 2);
      end else begin
        rd_block(ra, 2, DLY + 1, -1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_me_cache_dma_responder.md
# bp_me_cache_dma_responder

Memory-side responder for the bsg_cache DMA interface of one L2 bank. It accepts DMA packets, returns fill data for read packets and absorbs eviction data for write packets. Data is held in an internal flop-array backing store, and a programmable response delay models memory latency. One instance connects per bank to the `dma_pkt_o` / `dma_data_i` / `dma_data_o` triple of the cache slice. It serves as a synthesizable DRAM stand-in for simulation and FPGA bring-up.

## Interface
- `addr_width_p`, 28: DMA byte-address width (`daddr_width_p`).
- `fill_width_p`, 64: DMA beat width in bits (`l2_fill_width_p`); a power of two, ≥ 8.
- `block_width_p`, 512: cache block width in bits; a multiple of `fill_width_p`. Beats per block: `B = block_width_p / fill_width_p`.
- `mem_els_p`, 256: backing-store depth in `fill_width_p` words; a power of two, ≥ B.
- `delay_p`, 4: extra cycles between read-packet accept and the first fill beat; 0 is legal.
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `reset_n_i`, input, 1: asynchronous active-low reset.
- `dma_pkt_i`, input, `addr_width_p+1`: bit `[addr_width_p]` is `write_not_read`; bits `[addr_width_p-1:0]` are the byte address.
- `dma_pkt_v_i`, input, 1: packet valid.
- `dma_pkt_ready_and_o`, output, 1: packet ready; a transfer occurs when valid and ready are both high.
- `dma_data_o`, output, `fill_width_p`: fill beat to the cache.
- `dma_data_v_o`, output, 1: fill beat valid.
- `dma_data_ready_and_i`, input, 1: cache accepts the fill beat.
- `dma_data_i`, input, `fill_width_p`: eviction beat from the cache.
- `dma_data_v_i`, input, 1: eviction beat valid.
- `dma_data_ready_and_o`, output, 1: responder accepts the eviction beat.

## Operation
- FSM states:
  - `e_idle` → on packet accept: if read, go to `e_delay` (or directly to `e_read` when `delay_p == 0`); if write, go to `e_write`.
  - `e_delay`: the counter counts `delay_p` cycles, then goes to `e_read`.
  - `e_read` → `e_idle` after beat B-1 is accepted.
  - `e_write` → `e_idle` after beat B-1 is accepted.
- `dma_pkt_ready_and_o` = (state == `e_idle`). Exactly one packet is outstanding at a time.
- On accept, register the word index `base = addr >> log2(fill_width_p/8)`. Mask the low `log2(B)` bits of `base` to zero, so the block is aligned. Take the index modulo `mem_els_p`, so upper address bits alias.
- Beat counter `cnt`: `log2(B)` bits, cleared on accept. The word index is `(base + cnt) mod mem_els_p`.
- `e_read`:
  - `dma_data_v_o` = 1.
  - `dma_data_o` = `mem[base+cnt]`, read combinationally from the array.
  - `cnt` increments on `v & ready`.
  - `dma_data_o` stays stable while `dma_data_ready_and_i` is low.
- `e_write`:
  - `dma_data_ready_and_o` = 1.
  - On `dma_data_v_i`, write `mem[base+cnt]` ← `dma_data_i` and increment `cnt`.
  - Eviction beats offered while not in `e_write` are not accepted (ready = 0).
- Beats stream with no gaps between them when the peer is always ready.
- Outputs in all states: `dma_data_v_o` = 0 outside `e_read`; `dma_data_ready_and_o` = 0 outside `e_write`.
- Backing store is not reset. Contents survive reset; unwritten words read as X.

## Timing
- Reset (`reset_n_i` low, asynchronous):
  - State → `e_idle`; `cnt`, delay counter and `base` → 0.
  - While reset is asserted, `dma_pkt_ready_and_o`, `dma_data_v_o` and `dma_data_ready_and_o` are all 0. Gate ready with a flop set on the first clock edge after reset deasserts.
- Read, with the packet accepted at cycle 0:
  - Beat 0 is valid at cycle `1 + delay_p`.
  - With ready always high, beat B-1 is valid at cycle `delay_p + B`.
  - `dma_pkt_ready_and_o` is high again at cycle `delay_p + B + 1`.
- Write, with the packet accepted at cycle 0:
  - `dma_data_ready_and_o` is high from cycle 1.
  - With beats streaming, the final beat is written at cycle B and packet ready returns at cycle B+1.
- Read-after-write: the last write beat is committed at its accept edge. A read packet accepted the next cycle returns the new data.
- Backpressure: each low cycle on `dma_data_ready_and_i`, or gap in `dma_data_v_i`, delays completion by exactly one cycle.
- Reset mid-transfer: the transfer aborts immediately and no further beats are produced or consumed. Words already written stay written.

## Test plan
- Write then read:
  - Write packet to addr 0x40 (B=8), beats 0x11…0x88.
  - Read packet to 0x40 returns 0x11…0x88 in order.
  - Beat 0 appears 5 cycles after accept (`delay_p` = 4).
- Fill backpressure: toggle `dma_data_ready_and_i` 1,0,1,0…
  - Each beat holds value and valid while stalled.
  - Completion occurs 7 cycles later than the always-ready case.
- Aliasing and alignment:
  - Write block at addr 0x48 (unaligned); read at 0x40 returns the same data.
  - Write at 0x40 + `mem_els_p*8`; it overwrites the 0x40 contents.
- Single outstanding packet:
  - Hold `dma_pkt_v_i` high with a second packet during a read; it is accepted only after beat 7.
  - Eviction beats offered during `e_idle` or `e_read` see ready = 0.
- `delay_p` = 0 instance: read beat 0 is valid the cycle after accept. Back-to-back reads accept every 9 cycles.
- Reset at write beat 3, then deassert:
  - All outputs are 0 during reset.
  - Afterwards, words 0–2 hold new data, words 3–7 hold old data, and a new packet is accepted.
